// File: rtl/aes_block_unloader.sv
`default_nettype none
// ============================================================================
//  Module      : aes_block_unloader
//  Description : Captures one 128-bit AES result block over valid/ready and
//                shows it one byte at a time on 8 LEDs. Each press of a
//                step pushbutton moves to the next byte. After the last byte
//                the block is marked done, and one more press returns to idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_block_unloader #(
  parameter int NBYTES      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,          // asynchronous, active-low
  input  logic [8*NBYTES-1:0]   block_in,
  input  logic                  block_valid,
  output logic                  block_ready,
  input  logic                  step_btn,
  output logic [7:0]            byte_out,
  output logic [3:0]            byte_idx,
  output logic                  byte_valid,
  output logic                  done
);

  localparam int         c_W    = 8 * NBYTES;
  localparam logic [3:0] c_LAST = 4'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_stateNext;
  logic [c_W-1:0]       r_shift;
  logic [c_W-1:0]       w_shiftNext;
  logic [3:0]           r_idx;
  logic [3:0]           w_idxNext;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                 r_syncDly;
  logic                 w_stepPulse;

  // Bring the raw button into the clock domain and keep one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync    <= '0;
      r_syncDly <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], step_btn};
      r_syncDly <= r_sync[SYNC_STAGES-1];
    end
  end

  // A step is a rising edge at the synchronizer output. There is no debounce.
  assign w_stepPulse = r_sync[SYNC_STAGES-1] & ~r_syncDly;

  // State, display shift register and byte index
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_idx   <= 4'd0;
    end else begin
      r_state <= w_stateNext;
      r_shift <= w_shiftNext;
      r_idx   <= w_idxNext;
    end
  end

  // Next-state logic. A step in IDLE is ignored, so a step that arrives with the accept cannot skip byte 0.
  always_comb begin
    w_stateNext = r_state;
    w_shiftNext = r_shift;
    w_idxNext   = r_idx;
    case (r_state)
      IDLE: begin
        if (block_valid) begin
          w_shiftNext = block_in;
          w_idxNext   = 4'd0;
          w_stateNext = SHOW;
        end
      end
      SHOW: begin
        if (w_stepPulse) begin
          if (r_idx == c_LAST) begin
            // Clear the shift register so the LEDs go dark while done is shown
            w_shiftNext = '0;
            w_stateNext = DONE;
          end else begin
            w_shiftNext = r_shift << 8;
            w_idxNext   = r_idx + 4'd1;
          end
        end
      end
      DONE: begin
        if (w_stepPulse) begin
          w_idxNext   = 4'd0;
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only, so block_in has no combinational path to them
  assign block_ready = (r_state == IDLE);
  assign byte_valid  = (r_state == SHOW);
  assign done        = (r_state == DONE);
  assign byte_out    = r_shift[c_W-1 -: 8];
  assign byte_idx    = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_aes_block_unloader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_block_unloader
//  Description : Directed self-checking bench for aes_block_unloader
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_block_unloader;

  logic         clk;
  logic         rst;
  logic [127:0] block_in;
  logic         block_valid;
  logic         block_ready;
  logic         step_btn;
  logic [7:0]   byte_out;
  logic [3:0]   byte_idx;
  logic         byte_valid;
  logic         done;

  int errCnt = 0;
  int chkCnt = 0;

  logic [127:0] blk1 = 128'h00112233445566778899aabbccddeeff;
  logic [127:0] blk2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  logic [127:0] blkX = 128'hdeadbeefcafef00d0123456789abcdef;

  aes_block_unloader #(.NBYTES(16), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .block_in    (block_in),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .step_btn    (step_btn),
    .byte_out    (byte_out),
    .byte_idx    (byte_idx),
    .byte_valid  (byte_valid),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Clean button press: 6 clocks high, 6 clocks low, ending on a falling edge
  task automatic press();
    @(negedge clk) step_btn = 1'b1;
    repeat (6) @(negedge clk);
    step_btn = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  // One-cycle valid pulse. Returns at the falling edge after the accept edge.
  task automatic load(input logic [127:0] b);
    @(negedge clk);
    block_in    = b;
    block_valid = 1'b1;
    @(negedge clk);
    block_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] expB;
    rst = 1'b0; block_in = '0; block_valid = 1'b0; step_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(block_ready), 32'd1);
    chk("rst_bvalid", 32'(byte_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_idx", 32'(byte_idx), 32'd0);
    chk("rst_byte", 32'(byte_out), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // step while idle changes nothing
    press();
    chk("idle_step_ready", 32'(block_ready), 32'd1);
    chk("idle_step_bvalid", 32'(byte_valid), 32'd0);
    chk("idle_step_idx", 32'(byte_idx), 32'd0);

    // load first block
    load(blk1);
    chk("load_byte", 32'(byte_out), 32'h00);
    chk("load_idx", 32'(byte_idx), 32'd0);
    chk("load_bvalid", 32'(byte_valid), 32'd1);
    chk("load_ready", 32'(block_ready), 32'd0);

    // step through bytes 1..15
    for (int k = 1; k < 16; k++) begin
      press();
      expB = blk1[127 - 8*k -: 8];
      chk("step_byte", 32'(byte_out), 32'(expB));
      chk("step_idx", 32'(byte_idx), 32'(k));
      chk("step_bvalid", 32'(byte_valid), 32'd1);
    end
    press();
    chk("last_done", 32'(done), 32'd1);
    chk("last_bvalid", 32'(byte_valid), 32'd0);
    chk("last_byte", 32'(byte_out), 32'd0);
    chk("last_idx", 32'(byte_idx), 32'd15);
    chk("last_ready", 32'(block_ready), 32'd0);

    // a block offered in DONE is ignored
    load(blkX);
    chk("done_ignore_valid", 32'(done), 32'd1);

    // leave DONE
    press();
    chk("exit_done", 32'(done), 32'd0);
    chk("exit_ready", 32'(block_ready), 32'd1);
    chk("exit_idx", 32'(byte_idx), 32'd0);

    load(blk2);
    chk("blk2_byte0", 32'(byte_out), 32'h69);
    chk("blk2_bvalid", 32'(byte_valid), 32'd1);

    // block_valid held with different data during SHOW
    @(negedge clk);
    block_in = blkX; block_valid = 1'b1;
    press();
    chk("hold_byte1", 32'(byte_out), 32'hc4);
    press();
    chk("hold_byte2", 32'(byte_out), 32'he0);
    chk("hold_idx2", 32'(byte_idx), 32'd2);
    block_valid = 1'b0;

    // a one-clock glitch placed off the clock edge gives one advance
    @(posedge clk);
    #3 step_btn = 1'b1;
    #10 step_btn = 1'b0;
    repeat (8) @(negedge clk);
    chk("glitch_idx", 32'(byte_idx), 32'd3);
    chk("glitch_byte", 32'(byte_out), 32'hd8);

    // a slower press placed off the clock edge also gives one advance
    @(posedge clk);
    #7 step_btn = 1'b1;
    #47 step_btn = 1'b0;
    repeat (8) @(negedge clk);
    chk("async_idx", 32'(byte_idx), 32'd4);
    chk("async_byte", 32'(byte_out), 32'h6a);

    // reset in the middle of SHOW, with the button held through reset release
    @(negedge clk) rst = 1'b0;
    step_btn = 1'b1;
    @(negedge clk);
    chk("midrst_bvalid", 32'(byte_valid), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_ready", 32'(block_ready), 32'd1);
    chk("midrst_idx", 32'(byte_idx), 32'd0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    step_btn = 1'b0;
    repeat (6) @(negedge clk);
    chk("post_rst_ready", 32'(block_ready), 32'd1);
    chk("post_rst_byte", 32'(byte_out), 32'd0);

    // block_valid and step_pulse in the same IDLE cycle: byte 0 must not be skipped
    @(negedge clk) step_btn = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    block_in = blk1; block_valid = 1'b1;
    @(posedge clk);
    #1 block_valid = 1'b0;
    @(negedge clk);
    chk("coll_idx", 32'(byte_idx), 32'd0);
    chk("coll_byte", 32'(byte_out), 32'h00);
    chk("coll_bvalid", 32'(byte_valid), 32'd1);
    repeat (6) @(negedge clk);
    step_btn = 1'b0;
    repeat (6) @(negedge clk);
    chk("coll_hold_idx", 32'(byte_idx), 32'd0);
    press();
    chk("coll_next_idx", 32'(byte_idx), 32'd1);
    chk("coll_next_byte", 32'(byte_out), 32'h11);

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
`default_nettype wire
